// File: rtl/bus_slave_mem_if.sv
// ============================================================================
// Module   : bus_slave_mem_if
// Function : Bus responder for a synchronous 1-cycle-latency word RAM with a
//            programmable number of wait states (BUS_SLAVE_FAST_WR_EN: writes
//            finish after the first wait cycle).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_slave_mem_if #(
  parameter int MEM_AW      = 11,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_,
  input  logic              as_,
  input  logic              rw,
  input  logic [29:0]       addr,
  input  logic [31:0]       wr_data,
  output logic              rdy_,
  output logic [31:0]       rd_data,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [31:0]       mem_wr_data,
  input  logic [31:0]       mem_rd_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RDY  = 2'd2
  } state_t;

  localparam logic [3:0] C_WAIT_LAST = 4'(WAIT_CYCLES);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        rw_q;
  logic        cap_q;
  logic [31:0] data_q;
  logic [31:0] data_d;
  logic        wait_done_d;
  logic        w_req;
  logic        unused_addr_hi;

  assign w_req          = !cs_ && !as_;
  assign unused_addr_hi = ^addr[29:MEM_AW];

  // RAM data becomes valid the cycle after a read enable; fold it in directly
  // so the RDY transition can use it on the same edge it is captured.
  always_comb begin
    data_d = cap_q ? mem_rd_data : data_q;
  end

  always_comb begin
    wait_done_d = (cnt_q == C_WAIT_LAST);
`ifdef BUS_SLAVE_FAST_WR_EN
    if (!rw_q) begin
      wait_done_d = 1'b1;
    end
`else
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      rw_q        <= 1'b0;
      cap_q       <= 1'b0;
      data_q      <= 32'd0;
      rdy_        <= 1'b1;
      rd_data     <= 32'd0;
      mem_addr    <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_wr_data <= 32'd0;
    end else begin
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;
      cap_q   <= 1'b0;
      rdy_    <= 1'b1;
      rd_data <= 32'd0;

      case (state_q)
        ST_IDLE: begin
          if (w_req) begin
            mem_addr    <= addr[MEM_AW-1:0];
            mem_wr_data <= wr_data;
            rw_q        <= rw;
            cnt_q       <= 4'd1;
            mem_en      <= 1'b1;
            mem_we      <= !rw;
            data_q      <= 32'd0;
            state_q     <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          cnt_q  <= cnt_q + 4'd1;
          cap_q  <= mem_en && !mem_we;
          data_q <= data_d;
          // Abort wins over completion: a dropped strobe never sees rdy_.
          if (!w_req) begin
            data_q  <= 32'd0;
            state_q <= ST_IDLE;
          end else if (wait_done_d) begin
            rdy_    <= 1'b0;
            rd_data <= rw_q ? data_d : 32'd0;
            state_q <= ST_RDY;
          end
        end

        ST_RDY: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_slave_mem_if.sv
// Bench for bus_slave_mem_if: three instances (WAIT_CYCLES 2, 5, 4) each with
// a behavioural RAM; a scoreboard queue holds expected rdy_ cycles and data.
`default_nettype none

module tb_bus_slave_mem_if;

  localparam int ND = 3;
`ifdef BUS_SLAVE_FAST_WR_EN
  localparam int FAST = 1;
`else
  localparam int FAST = 0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        cs_n   [ND];
  logic        as_n   [ND];
  logic        rw_r   [ND];
  logic [29:0] addr_r [ND];
  logic [31:0] wd_r   [ND];
  logic        rdy_n  [ND];
  logic [31:0] rdd    [ND];
  logic [10:0] maddr  [ND];
  logic        men    [ND];
  logic        mwe    [ND];
  logic [31:0] mwd    [ND];

  int cyc   = 0;
  int total = 0;
  int bad   = 0;
  int mon_idx;

  typedef struct {
    int          d;
    int          cyc;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int WC = (g == 0) ? 2 : ((g == 1) ? 5 : 4);
    logic [31:0] mem [2048];
    logic [31:0] rdq;

    always @(posedge clk) begin
      if (men[g]) begin
        if (mwe[g]) mem[maddr[g]] <= mwd[g];
        else        rdq <= mem[maddr[g]];
      end
    end

    bus_slave_mem_if #(.MEM_AW(11), .WAIT_CYCLES(WC)) u_dut (
      .clk        (clk),
      .reset      (rst_n),
      .cs_        (cs_n[g]),
      .as_        (as_n[g]),
      .rw         (rw_r[g]),
      .addr       (addr_r[g]),
      .wr_data    (wd_r[g]),
      .rdy_       (rdy_n[g]),
      .rd_data    (rdd[g]),
      .mem_addr   (maddr[g]),
      .mem_en     (men[g]),
      .mem_we     (mwe[g]),
      .mem_wr_data(mwd[g]),
      .mem_rd_data(rdq)
    );
  end

  // Scoreboard monitor: every rdy_ pulse must match the oldest expectation
  // for that instance; rd_data must be zero whenever rdy_ is high.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < ND; d++) begin
        mon_idx = -1;
        for (int i = 0; i < sb.size(); i++)
          if (mon_idx < 0 && sb[i].d == d) mon_idx = i;
        if (rdy_n[d] === 1'b0) begin
          total++;
          if (mon_idx < 0) begin
            bad++;
            $display("FAIL rdy_unexpected dut%0d: rdy_=0 at cycle %0d, required 1", d, cyc);
          end else begin
            if (sb[mon_idx].cyc != cyc || rdd[d] !== sb[mon_idx].data) begin
              bad++;
              $display("FAIL rdy dut%0d: got cycle %0d data %h, required cycle %0d data %h",
                       d, cyc, rdd[d], sb[mon_idx].cyc, sb[mon_idx].data);
            end
            sb.delete(mon_idx);
          end
        end else begin
          if (mon_idx >= 0 && sb[mon_idx].cyc <= cyc) begin
            total++;
            bad++;
            $display("FAIL rdy_missing dut%0d: rdy_=%b at cycle %0d, required 0", d, rdy_n[d], cyc);
            sb.delete(mon_idx);
          end
          total++;
          if (rdd[d] !== 32'd0) begin
            bad++;
            $display("FAIL rd_data_idle dut%0d: got %h, required 00000000", d, rdd[d]);
          end
        end
      end
    end
  end

  task automatic idle_all();
    for (int d = 0; d < ND; d++) begin
      cs_n[d] = 1'b1; as_n[d] = 1'b1; rw_r[d] = 1'b1;
      addr_r[d] = 30'd0; wd_r[d] = 32'd0;
    end
  endtask

  // One bus access: request in cycle 0, strobe held until the RDY cycle.
  task automatic access(input int d, input bit rd, input logic [29:0] a,
                        input logic [31:0] wd, input logic [31:0] erd, input int lat);
    logic [10:0] ea;
    exp_t e;
    ea = a[10:0];
    @(negedge clk);
    cs_n[d] = 1'b0; as_n[d] = 1'b0; rw_r[d] = rd; addr_r[d] = a; wd_r[d] = wd;
    e.d = d; e.cyc = cyc + lat; e.data = rd ? erd : 32'd0;
    sb.push_back(e);
    @(negedge clk);
    total++;
    if (men[d] !== 1'b1 || mwe[d] !== !rd || maddr[d] !== ea) begin
      bad++;
      $display("FAIL mem_cycle1 dut%0d: en=%b we=%b addr=%h, required 1/%b/%h",
               d, men[d], mwe[d], maddr[d], !rd, ea);
    end
    if (!rd) begin
      total++;
      if (mwd[d] !== wd) begin
        bad++;
        $display("FAIL mem_wr_data dut%0d: got %h, required %h", d, mwd[d], wd);
      end
    end
    @(negedge clk);
    total++;
    if (men[d] !== 1'b0) begin
      bad++;
      $display("FAIL mem_en_pulse dut%0d: mem_en=%b in cycle 2, required 0", d, men[d]);
    end
    repeat (lat - 2) @(negedge clk);
    cs_n[d] = 1'b1; as_n[d] = 1'b1;
  endtask

  task automatic test_reset();
    idle_all();
    #2 rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        cs_n[d] = 1'($urandom); as_n[d] = 1'($urandom); rw_r[d] = 1'($urandom);
        addr_r[d] = 30'($urandom); wd_r[d] = $urandom;
      end
      #1;
      for (int d = 0; d < ND; d++) begin
        total++;
        if (rdy_n[d] !== 1'b1 || rdd[d] !== 32'd0 || men[d] !== 1'b0) begin
          bad++;
          $display("FAIL reset_hold dut%0d: rdy_=%b rd_data=%h mem_en=%b, required 1/0/0",
                   d, rdy_n[d], rdd[d], men[d]);
        end
      end
    end
    @(negedge clk);
    idle_all();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      total++;
      if (rdy_n[d] !== 1'b1 || men[d] !== 1'b0 || maddr[d] !== 11'd0) begin
        bad++;
        $display("FAIL reset_idle dut%0d: rdy_=%b mem_en=%b mem_addr=%h, required 1/0/000",
                 d, rdy_n[d], men[d], maddr[d]);
      end
    end
  endtask

  task automatic test_write_read();
    access(0, 1'b0, 30'h123, 32'hDEADBEEF, 32'd0, 3);
    access(0, 1'b1, 30'h123, 32'd0, 32'hDEADBEEF, 3);
  endtask

  task automatic test_wait5();
    access(1, 1'b0, 30'h040, 32'h5A5A1234, 32'd0, 6);
    access(1, 1'b1, 30'h040, 32'd0, 32'h5A5A1234, 6);
  endtask

  task automatic test_abort();
    access(0, 1'b0, 30'h7FF, 32'h0BADF00D, 32'd0, 3);
    @(negedge clk);
    cs_n[0] = 1'b0; as_n[0] = 1'b0; rw_r[0] = 1'b1; addr_r[0] = 30'h123;
    @(negedge clk);
    @(negedge clk);
    as_n[0] = 1'b1; cs_n[0] = 1'b1;
    @(negedge clk);
    total++;
    if (rdy_n[0] !== 1'b1) begin
      bad++;
      $display("FAIL abort dut0: rdy_=%b after abort, required 1", rdy_n[0]);
    end
    repeat (3) @(negedge clk);
    access(0, 1'b1, 30'h7FF, 32'd0, 32'h0BADF00D, 3);
  endtask

  task automatic test_back_to_back();
    access(0, 1'b0, 30'h0000_0001, 32'h11111111, 32'd0, 3);
    access(0, 1'b0, 30'h3FFF_F801, 32'h22222222, 32'd0, 3);
    access(0, 1'b1, 30'h0000_0001, 32'd0, 32'h22222222, 3);
  endtask

  task automatic test_fast_write();
    access(2, 1'b0, 30'h020, 32'hCAFEF00D, 32'd0, (FAST != 0) ? 2 : 5);
    access(2, 1'b1, 30'h020, 32'd0, 32'hCAFEF00D, 5);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cs_n[2] = 1'b0; as_n[2] = 1'b0; rw_r[2] = 1'b1; addr_r[2] = 30'h020;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (rdy_n[2] !== 1'b1 || rdd[2] !== 32'd0 || men[2] !== 1'b0 || mwe[2] !== 1'b0 ||
        maddr[2] !== 11'd0 || mwd[2] !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid dut2: rdy_=%b rd=%h en=%b we=%b addr=%h wd=%h, required 1/0/0/0/0/0",
               rdy_n[2], rdd[2], men[2], mwe[2], maddr[2], mwd[2]);
    end
    @(negedge clk);
    idle_all();
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wait5();
    test_abort();
    test_back_to_back();
    test_fast_write();
    test_reset_mid();
    repeat (10) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_slave_mem_if.md
# bus_slave_mem_if

Bus-side responder that answers CPU/bus-master accesses on the shared system bus by handshaking with `rdy_` and returning read data. It fronts a synchronous single-port word RAM with a 1-cycle read latency and inserts a programmable number of wait states. It sits behind the bus address decoder: the master's bus interface drives `as_`, `rw`, `addr`, `wr_data`, the decoder drives `cs_`, and this block answers with `rdy_` and `rd_data`.

## Interface
- `MEM_AW`, 11: RAM word-address width; `mem_addr = addr[MEM_AW-1:0]`, upper address bits ignored.
- `WAIT_CYCLES`, 2: cycles spent in WAIT before the ready cycle; legal range 2..15.
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-low.
- `cs_` in 1: chip select from the address decoder, active-low.
- `as_` in 1: address strobe from the master, active-low.
- `rw` in 1: 1 = read, 0 = write.
- `addr` in 30: word address.
- `wr_data` in 32: write data.
- `rdy_` out 1: ready, active-low, asserted for exactly one cycle per completed access.
- `rd_data` out 32: read data. Valid only while `rdy_`=0; forced to 0 otherwise so the bus can OR-mux slaves.
- `mem_addr` out MEM_AW: RAM address (registered).
- `mem_en` out 1: RAM enable pulse.
- `mem_we` out 1: RAM write enable, qualified by `mem_en`.
- `mem_wr_data` out 32: RAM write data (registered).
- `mem_rd_data` in 32: RAM read data, valid the cycle after `mem_en`=1 with `mem_we`=0.

## Operation
- FSM has three states: IDLE, WAIT, RDY. Reset state is IDLE.
- **IDLE:** when `cs_`=0 and `as_`=0 at a clock edge:
  - latch `addr[MEM_AW-1:0]`, `rw`, and `wr_data`;
  - load the wait counter (4 bits) with 1;
  - go to WAIT.
  - Otherwise stay in IDLE.
- **WAIT:**
  - In the first WAIT cycle, `mem_en`=1 and `mem_we`=!rw_latched.
  - The counter increments each cycle.
  - In the cycle after `mem_en` on a read, `mem_rd_data` is captured into an internal data register.
  - When counter == WAIT_CYCLES, go to RDY at the next edge.
- **RDY:** `rdy_`=0, and `rd_data` = captured register for a read or 0 for a write. Next state is IDLE unconditionally.
- **Abort:** if `cs_`=1 or `as_`=1 during WAIT, go to IDLE at the next edge with no `rdy_` pulse and discard captured data. A write already issued to the RAM remains committed.
- Inputs are ignored in WAIT and RDY except for the abort check. No request queueing.
- **Back-to-back:** a new request is accepted in IDLE the cycle after RDY. The master has deasserted `as_` by then, so a held strobe is not re-accepted.
- **Reset values** (reset=0, asynchronous): state IDLE, counter 0, `rdy_`=1, `rd_data`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wr_data`=0, data register 0.
- **Reset mid-operation:** the access is dropped immediately and no `rdy_` is produced. A RAM write pulse in flight is cut by the asynchronous clear.

## Timing
- Cycle 0: the request is sampled in IDLE.
- Cycle 1: first WAIT cycle, with `mem_en`/`mem_we` asserted.
- Cycle 2: read data from the RAM is captured at the end of the cycle.
- Cycle WAIT_CYCLES+1: RDY cycle, with `rdy_`=0.
- Total latency from request to ready is WAIT_CYCLES+1 cycles; default 3.
- Minimum request-to-request spacing is WAIT_CYCLES+2 cycles.
- `WAIT_CYCLES`≥2 guarantees read data is captured before RDY.
- All outputs are registered. No combinational path from bus inputs to `rdy_`/`rd_data`.

## Configuration
- `BUS_SLAVE_FAST_WR_EN`:
  - **Defined:** writes skip the remaining wait states. A write goes IDLE→WAIT (1 cycle, RAM write)→RDY, giving `rdy_` at cycle 2 regardless of WAIT_CYCLES. Reads are unchanged.
  - **Undefined:** writes use the full WAIT_CYCLES, with `rdy_` at cycle WAIT_CYCLES+1.

## Test plan
- **Reset check:** hold reset=0 with random inputs → `rdy_`=1, `rd_data`=0, `mem_en`=0. Release reset → FSM stays IDLE with `cs_`=`as_`=1.
- **Write then read:**
  - Write addr=0x0000_0123, wr_data=0xDEADBEEF → `mem_en`=`mem_we`=1, `mem_addr`=0x123 at cycle 1, `rdy_`=0 at cycle 3, `rd_data`=0.
  - Read the same address → `rdy_`=0 at cycle 3 with `rd_data`=0xDEADBEEF, and 0 in all other cycles.
- **WAIT_CYCLES=5:** a read → `rdy_` low exactly at cycle 6, for exactly one cycle.
- **Abort:** read request, then `as_`=1 during cycle 2 → no `rdy_` pulse. A following read of 0x7FF is served normally at latency 3.
- **Back-to-back with high address bits:** write 0x1/0x11111111, then at the first legal cycle write 0x3FFF_F801/0x22222222 (aliases to 0x001 with MEM_AW=11). A read of 0x1 → 0x22222222.
- **With `BUS_SLAVE_FAST_WR_EN`** and WAIT_CYCLES=4: a write → `rdy_` at cycle 2; a read → `rdy_` at cycle 5. Reset asserted at cycle 2 of a read → no `rdy_`, all outputs return to reset values.
